// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache with zero-latency hits and a
// single outstanding request/wait fill toward the memory controller.
module icache_responder #(
  parameter int SETS  = 16,
  parameter int IDX_W = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag  [SETS];
  logic [31:0]      r_data [SETS];
  logic [29:0]      r_miss_addr;
  logic [31:0]      r_hit_count;
  logic [31:0]      r_miss_count;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_fill_idx;
  logic [TAG_W-1:0] w_fill_tag;
  logic             w_hit;
  logic             w_miss;
  logic             w_fill;
  logic             w_unused;

  assign w_idx      = imemaddr[IDX_W+1:2];
  assign w_tag      = imemaddr[31:IDX_W+2];
  assign w_fill_idx = r_miss_addr[IDX_W-1:0];
  assign w_fill_tag = r_miss_addr[29:IDX_W];
  assign w_unused   = ^imemaddr[1:0];

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

  // Every output is forced to zero while RST is high, even if the state
  // register still holds FETCH from an abandoned fill.
  always_comb begin
    w_state_next = r_state;
    w_hit        = 1'b0;
    w_miss       = 1'b0;
    w_fill       = 1'b0;
    ihit         = 1'b0;
    imemload     = 32'h0;
    iREN         = 1'b0;
    iaddr        = 32'h0;
    if (!RST) begin
      case (r_state)
        IDLE: begin
          if (imemREN) begin
            if (r_valid[w_idx] && (r_tag[w_idx] == w_tag) && !flush) begin
              w_hit    = 1'b1;
              ihit     = 1'b1;
              imemload = r_data[w_idx];
            end else begin
              w_miss       = 1'b1;
              w_state_next = FETCH;
            end
          end
        end
        FETCH: begin
          iREN  = 1'b1;
          iaddr = {r_miss_addr, 2'b00};
          if (!iwait) begin
            w_fill       = 1'b1;
            w_state_next = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_miss_addr  <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_hit) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_miss) begin
        r_miss_addr  <= imemaddr[31:2];
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  // The fill's set comes after the flush clear so a frame filled in the
  // flush cycle survives while every other frame is invalidated.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid <= '0;
    end else begin
      if (flush) begin
        r_valid <= '0;
      end
      if (w_fill) begin
        r_valid[w_fill_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= iload;
    end
  end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Direct-mapped instruction cache that answers the datapath's fetch requests: imemREN, imemaddr in; ihit, imemload out.
- Hits are served combinationally from a tag/data array.
- Misses are filled from the memory controller over a request/wait handshake: iREN, iaddr out; iwait, iload in.
- Sits between the pipeline fetch stage and the memory arbiter. Keeps 32-bit hit and miss counters for performance checks.

Parameters:
- SETS, 16, number of one-word frames; power of two, at least 2.
- IDX_W, 4, log2(SETS); index = imemaddr[IDX_W+1:2], tag = imemaddr[31:IDX_W+2].

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- imemREN  input  1  datapath fetch request.
- imemaddr  input  32  fetch byte address; bits [1:0] ignored.
- ihit  output  1  requested word valid on imemload this cycle.
- imemload  output  32  instruction word.
- flush  input  1  invalidate all frames (pulse).
- iREN  output  1  fill read request to memory controller.
- iaddr  output  32  fill word address.
- iwait  input  1  high while memory has not yet delivered iload.
- iload  input  32  fill data, valid in the cycle iwait is low while iREN is high.
- hit_count  output  32  requests served as hits.
- miss_count  output  32  misses started.

Behaviour:
- Storage: per frame valid(1), tag(32-IDX_W-2), data(32).
- Reset: all valid bits cleared; FSM to IDLE; counters 0; ihit=0, iREN=0, iaddr=0, imemload=0 while RST is high. Reset mid-fill abandons the fill; no frame is written.
- FSM IDLE:
  - hit = imemREN & valid[idx] & tag[idx]==addr tag. On a hit, ihit=1 and imemload=data[idx] in the same cycle (zero latency), and hit_count increments.
  - On imemREN with no hit: latch {tag,idx} of imemaddr into the miss register, increment miss_count, go to FETCH.
  - ihit=0 whenever imemREN=0. imemload=0 whenever ihit=0.
- FSM FETCH:
  - iREN=1, iaddr={latched addr[31:2],2'b00}, ihit=0.
  - While iwait=1, stay in FETCH.
  - On the first cycle with iwait=0: write iload, latched tag, and valid=1 into the latched frame; go to IDLE.
  - The next cycle hits if imemaddr still matches.
- Miss latency: memory wait cycles + 1 (fill cycle) + 1 (hit cycle). No read-forwarding of iload.
- imemaddr changes during FETCH (branch redirect): the fill of the latched address still completes. The new address is evaluated only in IDLE.
- imemREN drops during FETCH: the fill still completes.
- flush:
  - In IDLE: clears all valid bits at the next edge; ihit forced 0 that cycle.
  - During FETCH: clears all valid bits, the in-flight fill is still written and remains valid, and FSM returns to IDLE normally.
  - flush and fill-complete in the same cycle: the filled frame ends valid; all others invalid.
- Conflict: a fill evicts a frame unconditionally (no dirty state, read-only cache).
- Counters wrap from 0xFFFFFFFF to 0 and are cleared only by RST.
- iREN never asserts in IDLE; at most one outstanding fill.

Test Plan:
- Reset then imemREN=1, imemaddr=0x00000000, iwait=1 for 3 cycles then 0 with iload=0x8C010004: iREN=1 and iaddr=0 for 4 cycles, ihit=0 throughout; next cycle ihit=1, imemload=0x8C010004; miss_count=1, hit_count=1.
- Re-fetch 0x00000000 for 5 consecutive cycles: ihit=1 every cycle, iREN=0, hit_count increases by 5.
- Conflict (SETS=16): fetch 0x00000004 (fill 0x11111111), then 0x00000044 (fill 0x22222222), then 0x00000004: third fetch misses again; miss_count=3; final imemload=0x11111111.
- Redirect: miss on 0x00000010 with iwait held high 2 cycles; change imemaddr to 0x00000020 in cycle 1. The fill completes for iaddr=0x10; 0x20 then misses; a later fetch of 0x10 hits.
- flush: fill 0x00000008 so it hits, pulse flush=1 for one cycle, then fetch 0x00000008: ihit=0 in the flush cycle, then a fresh miss (iREN=1, iaddr=0x08).
- RST asserted in the 2nd FETCH cycle of a miss to 0x0000000C: iREN=0 the next cycle; counters=0; a later fetch of 0x0C misses; no stale hit.
